// File: rtl/nibble_assembler.sv
// Collects NIBBLES valid nibbles (little-end first) into a word and buffers words in a FIFO.
// Optional build macro NIBBLE_ASM_DROP_CNT_EN adds the saturating drop_cnt output.
module nibble_assembler #(
    parameter int NIBBLES = 2,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   data_bus,
    input  logic                         valid,
    output logic [4*NIBBLES-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
`ifdef NIBBLE_ASM_DROP_CNT_EN
    ,
    output logic [7:0]                   drop_cnt
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int HW = 4 * (NIBBLES - 1);
    localparam int IW = $clog2(NIBBLES);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    // Handshake: a word leaves the FIFO on any rising edge where out_valid and out_ready are both 1;
    // the producer side has no ready, so a word completed into a full FIFO (with no pop) is dropped.

    typedef enum logic {EMPTY_WORD, PARTIAL} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [HW-1:0]   hold, hold_n;
    logic            push;
    logic [W-1:0]    word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY_WORD;
            idx   <= '0;
            hold  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            hold  <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        hold_n  = hold;
        push    = 1'b0;
        word    = {data_bus, hold};
        if (valid) begin
            case (state)
                EMPTY_WORD: begin
                    hold_n[3:0] = data_bus;
                    idx_n       = IW'(1);
                    state_n     = PARTIAL;
                end
                PARTIAL: begin
                    if (idx == IW'(NIBBLES - 1)) begin
                        push    = 1'b1;
                        idx_n   = '0;
                        state_n = EMPTY_WORD;
                    end else begin
                        for (int i = 1; i < NIBBLES - 1; i++) begin
                            if (idx == IW'(i)) hold_n[4*i +: 4] = data_bus;
                        end
                        idx_n = idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          pop, full, push_ok, drop;

    assign pop     = out_valid & out_ready;
    assign full    = (count == LW'(DEPTH));
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    assign out_valid = (count != '0);
    assign level     = count;
    assign out_data  = mem[rd_ptr];

`ifdef NIBBLE_ASM_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_nibble_assembler.sv
// Bench for nibble_assembler: directed scenarios with literal expectations plus random traffic
// checked every cycle against a queue-based model of assembly and buffering.
module tb_nibble_assembler;
    localparam int NIBBLES = 2;
    localparam int DEPTH   = 4;
    localparam int W       = 4 * NIBBLES;
    localparam int LW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    data_bus = '0;
    logic          valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef NIBBLE_ASM_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    nibble_assembler #(.NIBBLES(NIBBLES), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_bus  (data_bus),
        .valid     (valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
`ifdef NIBBLE_ASM_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // model: pending nibbles, buffered words, sticky flag, drop total
    logic [3:0]   part_q[$];
    logic [W-1:0] exp_q[$];
    bit           m_ovf = 1'b0;
    int           m_drops = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            part_q.delete();
            exp_q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            bit           have_word;
            logic [W-1:0] w;
            have_word = 1'b0;
            w = '0;
            if (valid) begin
                part_q.push_back(data_bus);
                if (part_q.size() == NIBBLES) begin
                    for (int i = 0; i < NIBBLES; i++) w = w | (W'(part_q[i]) << (4 * i));
                    part_q.delete();
                    have_word = 1'b1;
                end
            end
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (have_word) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(w);
                else begin
                    m_ovf   = 1'b1;
                    m_drops = m_drops + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("level", 32'(level), 32'(exp_q.size()));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (exp_q.size() > 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
`ifdef NIBBLE_ASM_DROP_CNT_EN
            chk("drop_cnt", 32'(drop_cnt), 32'((m_drops > 255) ? 255 : m_drops));
`endif
        end
    end

    // driver tasks: called at a falling edge, return at the falling edge after the sampling edge
    task automatic nib(input logic [3:0] n);
        data_bus = n;
        valid    = 1'b1;
        @(negedge clk);
        valid    = 1'b0;
        data_bus = 4'($urandom_range(0, 15));
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_level", 32'(level), 32'h0);

        // basic assembly
        out_ready = 1'b1;
        nib(4'h5);
        nib(4'hA);
        chk("basic_valid", 32'(out_valid), 32'h1);
        chk("basic_data", 32'(out_data), 32'hA5);
        idle(1);
        chk("basic_one_cycle", 32'(out_valid), 32'h0);

        // gapped input
        nib(4'h3);
        idle(5);
        chk("gap_level", 32'(level), 32'h0);
        nib(4'hC);
        chk("gap_level_done", 32'(level), 32'h1);
        chk("gap_data", 32'(out_data), 32'hC3);
        idle(1);

        // fill, overflow, drain in order
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            nib(4'(k));
            nib(4'h1);
        end
        chk("fill_level", 32'(level), 32'h4);
        chk("fill_ovf", 32'(overflow), 32'h1);
`ifdef NIBBLE_ASM_DROP_CNT_EN
        chk("fill_drop_cnt", 32'(drop_cnt), 32'h1);
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_data", 32'(out_data), 32'h10 + 32'(k));
            idle(1);
        end
        chk("drain_empty", 32'(out_valid), 32'h0);

        // simultaneous push and pop at full
        pulse_rst();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nib(4'(k));
            nib(4'h2);
        end
        nib(4'h4);
        out_ready = 1'b1;
        nib(4'h2);
        chk("pp_level", 32'(level), 32'h4);
        chk("pp_ovf", 32'(overflow), 32'h0);
        for (int k = 1; k < 5; k++) begin
            chk("pp_order", 32'(out_data), 32'h20 + 32'(k));
            idle(1);
        end
        chk("pp_empty", 32'(out_valid), 32'h0);

        // reset mid-operation
        out_ready = 1'b0;
        nib(4'h7); nib(4'h8); nib(4'h9); nib(4'hA); nib(4'hB);
        pulse_rst();
        chk("mid_rst_level", 32'(level), 32'h0);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_ovf", 32'(overflow), 32'h0);
        out_ready = 1'b1;
        nib(4'h1);
        nib(4'h2);
        chk("mid_rst_data", 32'(out_data), 32'h21);
        idle(1);

        // sustained drops (saturates drop_cnt when built in)
        out_ready = 1'b0;
        for (int k = 0; k < 304; k++) begin
            nib(4'($urandom_range(0, 15)));
            nib(4'($urandom_range(0, 15)));
        end
        chk("sat_ovf", 32'(overflow), 32'h1);
`ifdef NIBBLE_ASM_DROP_CNT_EN
        chk("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
`endif

        // random traffic
        pulse_rst();
        for (int c = 0; c < 3000; c++) begin
            valid     = ($urandom_range(0, 3) != 0);
            data_bus  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0) ^ (c / 500 % 2 == 1);
            @(negedge clk);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_assembler.md
# nibble_assembler

Receive-side endpoint for the 4-bit `data_bus`/`valid` nibble stream driven by the submodule instances in this design. It collects `NIBBLES` consecutive valid nibbles into one word, little-end first, and buffers completed words in a small FIFO. The FIFO feeds a ready/valid consumer. The producer has no backpressure, so the block detects and flags words lost to a full FIFO and never stalls the stream.

## Interface
Parameters:
- `NIBBLES`, default 2: nibbles per assembled word, range 2..8; `out_data` width is 4*NIBBLES.
- `DEPTH`, default 4: FIFO depth in words, power of two, range 2..16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_bus`  in  4  nibble from the producer; sampled only when `valid`=1.
- `valid`  in  1  nibble qualifier; one nibble per cycle when high.
- `out_data`  out  4*NIBBLES  word at the FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the word; a pop occurs when `out_valid` and `out_ready` are both 1.
- `level`  out  $clog2(DEPTH+1)  number of words in the FIFO.
- `overflow`  out  1  sticky flag: at least one completed word was dropped.
- `drop_cnt`  out  8  dropped-word count; present only with `NIBBLE_ASM_DROP_CNT_EN`.

## Operation
- Assembly uses the nibble index `idx` (0..NIBBLES-1) and the holding register `hold`, which holds nibbles 0..NIBBLES-2.
- States: EMPTY_WORD (idx=0) and PARTIAL (idx>0).
- On `valid`=1 with idx<NIBBLES-1: the nibble is written to `hold[4*idx +: 4]` and idx increments. The state moves EMPTY_WORD→PARTIAL.
- On `valid`=1 with idx=NIBBLES-1: the word is `{data_bus, hold[4*(NIBBLES-1)-1:0]}`, so nibble 0 occupies the LSBs. The word is presented for push, and idx returns to 0 (PARTIAL→EMPTY_WORD).
- `valid`=0 holds idx and `hold`. Gaps between nibbles are unlimited, and there is no timeout.
- FIFO: a circular buffer with `wr_ptr`/`rd_ptr` of width $clog2(DEPTH) and a separate count. Pointers wrap from DEPTH-1 to 0.
- Push is accepted when count<DEPTH, or when count=DEPTH and a pop happens in the same cycle.
- Push while full with no pop: the word is dropped, `overflow` is set to 1 and stays set until `rst`. The FIFO contents, pointers and assembly continue unaffected.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Pop on empty is impossible, because `out_valid`=0.
- `out_data` always reflects `mem[rd_ptr]`. Its value is don't-care when `out_valid`=0.

## Timing
- Reset values: idx=0, `hold`=0, pointers=0, `level`=0, `out_valid`=0, `out_data`=0 (memory cleared), `overflow`=0, `drop_cnt`=0.
- Asserting `rst` mid-word or mid-burst immediately discards the partial word and all buffered words.
- Latency: a word pushed at rising edge T has `out_valid`=1 and valid `out_data` during cycle T+1.
- `level` and `out_valid` are registered and reflect pushes and pops of the previous edge.
- `out_valid`/`out_data` do not depend combinationally on `out_ready`.
- Throughput: one word every NIBBLES cycles at full `valid` rate, sustained indefinitely with `out_ready`=1.

## Configuration
- `NIBBLE_ASM_DROP_CNT_EN` defined:
  - Adds the `drop_cnt` port, an 8-bit counter incremented on every dropped word.
  - The counter saturates at 255 and is cleared only by `rst`.
- Not defined: the `drop_cnt` port and its register are absent. `overflow` behaves identically in both builds.

## Test plan
- Basic assembly: NIBBLES=2, `out_ready`=1, nibbles 0x5 then 0xA on consecutive cycles → `out_data`=0xA5 with `out_valid`=1 for exactly one cycle, one cycle after the 0xA edge.
- Gapped input: nibble 0x3, then `valid`=0 for 5 cycles, then 0xC → a single word 0xC3. `level` stays 0 until the completing edge.
- Fill, overflow and wrap: `out_ready`=0, push 5 words 0x10..0x14 with DEPTH=4 → `level`=4, `overflow`=1, `drop_cnt`=1 (if enabled). Then `out_ready`=1 → pops 0x10, 0x11, 0x12, 0x13 in order, and `out_valid`=0 afterwards.
- Simultaneous push/pop at full: FIFO full, last nibble arrives with `out_ready`=1 → no drop, `overflow` stays 0, `level` stays 4, and the new word appears after the three older ones.
- Reset mid-operation: 2 words buffered plus 1 partial nibble, assert `rst` for 1 cycle → `level`=0, `out_valid`=0, `overflow`=0. The next nibble pair 0x1, 0x2 yields 0x21, proving idx was cleared.
- Counter saturation (macro on): 300 dropped words → `drop_cnt`=255.
